// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues word requests and buffers responses in a PC-tagged prefetch FIFO.
// Optional macro IFQ_BYPASS_EN forwards a response straight to the core when the FIFO is empty.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    state_t        state;
    state_t        state_next;
    fetch_entry_t  fifo_mem [DEPTH];
    logic [31:0]   tag_mem  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] tag_wr_ptr;
    logic [AW-1:0] tag_rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] stale;
    logic [31:0]   fetch_pc;

    logic          head_valid;
    logic          credit;
    logic          accept;
    logic          rsp_live;
    logic          stale_dec;
    logic          fifo_push;
    logic          fifo_pop;
    logic          bypass_take;
    logic [SW-1:0] inflight;
    logic [CW-1:0] stale_on_redirect;
    logic [CW-1:0] stale_after;

    assign head_valid = (count != '0);
    assign credit     = (SW'(count) + SW'(outstanding)) < SW'(DEPTH);
    assign mem_req    = ~reset & (state == FETCH) & ~halt & credit;
    assign accept     = mem_req & mem_ready;
    assign mem_addr   = fetch_pc;

    // A response is live only when no stale responses remain ahead of it and no redirect is flushing it.
    assign rsp_live   = mem_rvalid & ~redirect & (stale == '0) & ~reset;
    assign stale_dec  = mem_rvalid & (stale != '0);
    assign stale_after = stale - CW'(stale_dec);

    // Everything still in flight after this cycle becomes stale on a redirect.
    assign inflight = SW'(stale) + SW'(outstanding) + SW'(accept);
    assign stale_on_redirect = (mem_rvalid && inflight != '0) ? CW'(inflight - SW'(1)) : CW'(inflight);

    // Consumer view: registered FIFO head, optionally overridden by a same-cycle response.
    always_comb begin
        inst_valid  = head_valid;
        inst_data   = fifo_mem[rd_ptr].instr;
        inst_pc     = fifo_mem[rd_ptr].pc;
        bypass_take = 1'b0;
`ifdef IFQ_BYPASS_EN
        if (!head_valid && rsp_live) begin
            inst_valid  = 1'b1;
            inst_data   = mem_rdata;
            inst_pc     = tag_mem[tag_rd_ptr];
            bypass_take = inst_ready;
        end
`endif
    end

    assign fifo_pop  = head_valid & inst_ready;
    assign fifo_push = rsp_live & ~bypass_take;

    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (halt) state_next = HALT;
            DRAIN:   if (stale_after == '0) state_next = FETCH;
            HALT:    if (!halt) state_next = FETCH;
            default: state_next = FETCH;
        endcase
        if (redirect) begin
            if (stale_on_redirect != '0) state_next = DRAIN;
            else if (halt)               state_next = HALT;
            else                         state_next = FETCH;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FETCH;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr_ptr  <= '0;
            tag_rd_ptr  <= '0;
            count       <= '0;
            outstanding <= '0;
            stale       <= '0;
            fetch_pc    <= RESET_PC;
            for (int unsigned i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            state <= state_next;
            if (redirect) begin
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                tag_wr_ptr  <= '0;
                tag_rd_ptr  <= '0;
                count       <= '0;
                outstanding <= '0;
                stale       <= stale_on_redirect;
                fetch_pc    <= redirect_pc;
            end else begin
                if (fifo_push) begin
                    fifo_mem[wr_ptr] <= '{pc: tag_mem[tag_rd_ptr], instr: mem_rdata};
                    wr_ptr           <= wr_ptr + AW'(1);
                end
                if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(fifo_push) - CW'(fifo_pop);
                if (accept) begin
                    tag_wr_ptr <= tag_wr_ptr + AW'(1);
                    fetch_pc   <= fetch_pc + 32'd1;
                end
                if (rsp_live) tag_rd_ptr <= tag_rd_ptr + AW'(1);
                outstanding <= outstanding + CW'(accept) - CW'(rsp_live);
                stale       <= stale_after;
            end
        end
    end

    // PC tags of in-flight requests, popped in response order.
    always_ff @(posedge clock) begin
        if (accept && !redirect) tag_mem[tag_wr_ptr] <= fetch_pc;
    end

endmodule
